// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for one NPU MAC lane.
// Multiplies two unsigned WIDTH-bit operands by shift-and-add over exactly
// WIDTH cycles using one time-shared ripple adder, then adds the 2*WIDTH-bit
// product into an ACC_WIDTH-bit running sum with a sticky wrap flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid            in_ready  ready for an operand pair
//   a, b       multiplicand / multiplier     clear_acc start this op from acc=0
//   out_valid  acc_out holds a new result    out_ready downstream takes result
//   acc_out    accumulator value             overflow  sticky accumulator wrap
//   busy       sequencer not idle

module Full_Adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module mac_seq_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clear_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 overflow,
    output logic                 busy
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_ACC, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PW-1:0]        r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [PW-1:0]        r_prod;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_clr_pend;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    logic [PW-1:0]        w_addend;
    logic [PW-1:0]        w_prod_sum;
    logic [PW-1:0]        w_carry;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH:0]   w_acc_sum;

    // Shared product adder: the multiplicand is added only when the current
    // multiplier LSB is set. The product never exceeds PW bits, so the MSB
    // cell needs no carry out.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    for (genvar gi = 0; gi < PW - 1; gi++) begin : g_ripple
        Full_Adder u_fa (
            .i_a    (r_prod[gi]),
            .i_b    (w_addend[gi]),
            .i_cin  (w_carry[gi]),
            .o_sum  (w_prod_sum[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    assign w_prod_sum[PW-1] = r_prod[PW-1] ^ w_addend[PW-1] ^ w_carry[PW-1];

    // Accumulate at ACC_WIDTH+1 bits so the top bit flags a wrap.
    assign w_base    = r_clr_pend ? '0 : r_acc;
    assign w_acc_sum = {1'b0, w_base} + (ACC_WIDTH+1)'(r_prod);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)                      w_next = S_MULT;
            S_MULT: if (r_cnt == CNT_W'(WIDTH - 1))    w_next = S_ACC;
            S_ACC:                                     w_next = S_DONE;
            S_DONE: if (out_ready)                     w_next = S_IDLE;
            default:                                   w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign acc_out  = r_acc;
    assign overflow = r_ovf;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_cnt      <= '0;
            r_clr_pend <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= PW'(a);
                        r_mplier   <= b;
                        r_prod     <= '0;
                        r_cnt      <= '0;
                        r_clr_pend <= clear_acc;
                    end
                end
                S_MULT: begin
                    r_prod   <= w_prod_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_ACC: begin
                    r_acc <= w_acc_sum[ACC_WIDTH-1:0];
                    r_ovf <= (r_clr_pend ? 1'b0 : r_ovf) | w_acc_sum[ACC_WIDTH];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl (WIDTH=8, ACC_WIDTH=20) plus a random
// sweep checked against a modulo-2^20 reference model.

module tb_mac_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        clear_acc;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc_out;
    logic        overflow;
    logic        busy;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    mac_seq_ctrl #(.WIDTH(8), .ACC_WIDTH(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clear_acc (clear_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    // One full transaction; out_ready held low for 'stall' cycles in DONE.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic iclr,
                         input int unsigned stall, input logic [19:0] eacc,
                         input logic eovf, input string tag);
        int unsigned k;
        logic        saw_ready;
        @(negedge clk);
        wait_idle();
        a = ia; b = ib; clear_acc = iclr; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid  = 1'b0;
        a         = 8'($urandom);
        b         = 8'($urandom);
        clear_acc = 1'($urandom);
        saw_ready = in_ready;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
            saw_ready |= in_ready;
        end
        check({tag, " latency"}, k, 32'd9);
        check({tag, " in_ready_low"}, 32'(saw_ready), 32'd0);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check({tag, " out_valid_held"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        check({tag, " acc_out"}, 32'(acc_out), 32'(eacc));
        check({tag, " overflow"}, 32'(overflow), 32'(eovf));
    endtask

    logic [19:0] m_acc;
    logic        m_ovf;
    logic [20:0] m_sum;
    logic [7:0]  ra, rb;
    logic        rc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; clear_acc = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst acc_out",   32'(acc_out),   32'd0);
        check("rst overflow",  32'(overflow),  32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst busy",      32'(busy),      32'd0);
        rst_n = 1'b1;

        do_op(8'd3, 8'd5, 1'b1, 0, 20'd15, 1'b0, "t1_3x5");
        do_op(8'd7, 8'd9, 1'b0, 0, 20'd78, 1'b0, "t2_7x9");
        do_op(8'd4, 8'd0, 1'b0, 0, 20'd78, 1'b0, "t2_4x0");

        // 255*255 = 65025; 16 ops -> 1040400, 17th wraps to 56849
        for (int unsigned i = 1; i <= 17; i++)
            do_op(8'd255, 8'd255, (i == 1), 0, 20'(i * 65025), (i >= 17), "t3_ovf");

        // Backpressure: 1*1 -> 56850, held while out_ready=0 and a new pair waits
        @(negedge clk);
        wait_idle();
        a = 8'd1; b = 8'd1; clear_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 8'd9; b = 8'd9; clear_acc = 1'b0;
        for (int unsigned k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        check("t4 acc_out", 32'(acc_out), 32'd56850);
        check("t4 overflow", 32'(overflow), 32'd1);
        for (int unsigned s = 0; s < 5; s++) begin
            @(negedge clk);
            check("t4 stall out_valid", 32'(out_valid), 32'd1);
            check("t4 stall acc_out",   32'(acc_out),   32'd56850);
            check("t4 stall overflow",  32'(overflow),  32'd1);
            check("t4 stall in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 released out_valid", 32'(out_valid), 32'd0);
        check("t4 released in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4 queued accepted busy", 32'(busy), 32'd1);
        for (int unsigned k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        check("t4 queued acc_out",  32'(acc_out),  32'd56931);
        check("t4 queued overflow", 32'(overflow), 32'd1);

        do_op(8'd2, 8'd2, 1'b1, 0, 20'd4, 1'b0, "t3_op18");

        // Reset during MULT with cnt=3
        @(negedge clk);
        wait_idle();
        a = 8'd3; b = 8'd3; clear_acc = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5 cnt before reset", 32'(dut.r_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t5 busy",      32'(busy),      32'd0);
        check("t5 in_ready",  32'(in_ready),  32'd1);
        check("t5 acc_out",   32'(acc_out),   32'd0);
        check("t5 overflow",  32'(overflow),  32'd0);
        check("t5 out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd1, 8'd1, 1'b0, 0, 20'd1, 1'b0, "t5_post");

        // Random sweep vs. reference model
        m_acc = 20'd1;
        m_ovf = 1'b0;
        for (int unsigned n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = ($urandom_range(0, 7) == 0);
            m_sum = {1'b0, (rc ? 20'd0 : m_acc)} + (21'(ra) * 21'(rb));
            m_ovf = (rc ? 1'b0 : m_ovf) | m_sum[20];
            m_acc = m_sum[19:0];
            do_op(ra, rb, rc, $urandom_range(0, 3), m_acc, m_ovf, "t6_rand");
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
